// File: rtl/aes_v2_sub_size_pkg.sv
// rtl/aes_v2_sub_size_pkg.sv - shared constants, step encodings and GF(2^8) helpers for the byte-serial S-box unit
package aes_v2_sub_size_pkg;

    localparam logic [7:0] AFFINE_CONST = 8'h63;
    // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1 (0x11b)
    localparam logic [7:0] FIELD_POLY   = 8'h1b;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } step_e;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? FIELD_POLY : 8'h00);
        end
        return acc;
    endfunction

    // x^254 == x^-1 for x != 0, and 0 maps to 0 for free
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned k);
        return (b << k) | (b >> (8 - k));
    endfunction

    // Linear part of the forward affine map (constant added separately)
    function automatic logic [7:0] affine_fwd(input logic [7:0] b);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4);
    endfunction

    // Inverse of the linear part above
    function automatic logic [7:0] affine_inv(input logic [7:0] b);
        return rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6);
    endfunction

endpackage

// File: rtl/aes_v2_sbox_core.sv
// rtl/aes_v2_sbox_core.sv - combinational AES S-box / inverse S-box sharing one field inverter
// Ports: din (byte in), enc (1 = S, 0 = S^-1), dout (byte out)
module aes_v2_sbox_core
    import aes_v2_sub_size_pkg::*;
(
    input  logic [7:0] din,
    input  logic       enc,
    output logic [7:0] dout
);

    logic [7:0] inv_in;
    logic [7:0] inv_out;

    always_comb begin
        // Decrypt undoes the affine step before inversion; encrypt applies it after
        inv_in  = enc ? din : affine_inv(din ^ AFFINE_CONST);
        inv_out = gf_inv(inv_in);
        dout    = enc ? (affine_fwd(inv_out) ^ AFFINE_CONST) : inv_out;
    end

endmodule

// File: rtl/aes_v2_sub_size.sv
// rtl/aes_v2_sub_size.sv - byte-serial 4-byte SubBytes/InvSubBytes unit, one S-box evaluation per cycle
// Ports: g_clk, g_resetn (sync active-low), valid/ready handshake, rs1 (bytes 0,1), rs2 (bytes 2,3), enc, rd (result)
module aes_v2_sub_size
    import aes_v2_sub_size_pkg::*;
(
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        valid,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        enc,
    output logic        ready,
    output logic [31:0] rd
);

    step_e      step_q;
    step_e      step_d;
    logic [7:0] b0_q, b1_q, b2_q;
    logic [7:0] step_in;
    logic [7:0] step_out;
    logic       unused_hi_bytes;

    assign unused_hi_bytes = ^{rs1[31:16], rs2[15:0]};

    always_comb begin
        step_in = rs1[7:0];
        case (step_q)
            S0: step_in = rs1[7:0];
            S1: step_in = rs1[15:8];
            S2: step_in = rs2[23:16];
            S3: step_in = rs2[31:24];
            default: step_in = rs1[7:0];
        endcase
    end

    aes_v2_sbox_core u_sbox_core (
        .din  (step_in),
        .enc  (enc),
        .dout (step_out)
    );

    always_ff @(posedge g_clk) begin
        if (!g_resetn) step_q <= S0;
        else           step_q <= step_d;
    end

    // Any cycle without valid sends the counter home, which covers both idle hold and abort
    always_comb begin
        step_d = S0;
        ready  = 1'b0;
        if (valid) begin
            if (step_q == S3) begin
                ready  = 1'b1;
                step_d = S0;
            end else begin
                step_d = step_e'(step_q + 2'd1);
            end
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            b0_q <= 8'h00;
            b1_q <= 8'h00;
            b2_q <= 8'h00;
        end else if (valid) begin
            if (step_q == S0) b0_q <= step_out;
            if (step_q == S1) b1_q <= step_out;
            if (step_q == S2) b2_q <= step_out;
        end
    end

    // Byte 3 comes straight from the S-box in the completing cycle
    assign rd = {step_out, b2_q, b1_q, b0_q};

endmodule

// File: tb/tb_aes_v2_sub_size.sv
// tb/tb_aes_v2_sub_size.sv - self-checking bench for aes_v2_sub_size
module tb_aes_v2_sub_size;

    logic        g_clk;
    logic        g_resetn;
    logic        valid;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        enc;
    logic        ready;
    logic [31:0] rd;

    int checks   = 0;
    int failures = 0;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];
    int         run_len;
    logic       cmp_on;

    aes_v2_sub_size dut (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .valid    (valid),
        .rs1      (rs1),
        .rs2      (rs2),
        .enc      (enc),
        .ready    (ready),
        .rd       (rd)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        int p;
        int aa;
        p  = 0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa << 1;
            if (aa >= 256) aa = aa ^ 32'h11b;
        end
        return p[7:0];
    endfunction

    function automatic logic [7:0] ref_inv(input logic [7:0] x);
        if (x == 8'h00) return 8'h00;
        for (int y = 1; y < 256; y++)
            if (ref_mul(x, y[7:0]) == 8'h01) return y[7:0];
        return 8'h00;
    endfunction

    function automatic logic [7:0] ref_sbox(input logic [7:0] x);
        logic [7:0] y;
        logic [7:0] c;
        logic [7:0] o;
        y = ref_inv(x);
        c = 8'h63;
        for (int i = 0; i < 8; i++)
            o[i] = y[i] ^ y[(i + 4) % 8] ^ y[(i + 5) % 8] ^ y[(i + 6) % 8] ^ y[(i + 7) % 8] ^ c[i];
        return o;
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a, input logic [31:0] b, input logic e);
        logic [7:0] x [4];
        logic [31:0] r;
        x[0] = a[7:0];
        x[1] = a[15:8];
        x[2] = b[23:16];
        x[3] = b[31:24];
        for (int i = 0; i < 4; i++)
            r[i*8 +: 8] = e ? fwd_tab[x[i]] : inv_tab[x[i]];
        return r;
    endfunction

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Model: the op completes on the 4th consecutive valid cycle since reset / last completion / last gap
    always @(posedge g_clk) begin
        if (!g_resetn)   run_len <= 0;
        else if (!valid) run_len <= 0;
        else             run_len <= (run_len == 3) ? 0 : run_len + 1;
    end

    always @(negedge g_clk) begin
        if (cmp_on) begin
            logic exp_ready;
            exp_ready = valid && (run_len == 3);
            check32("ready_model", {31'd0, ready}, {31'd0, exp_ready});
            if (exp_ready)
                check32("rd_model", rd, model_rd(rs1, rs2, enc));
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic e, input int ncyc,
                          input logic check_lit, input logic [31:0] lit, output logic [31:0] got);
        got   = 32'h0;
        rs1   = a;
        rs2   = b;
        enc   = e;
        valid = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge g_clk);
            check32("ready_cycle", {31'd0, ready}, {31'd0, (i % 4) == 3});
            if (ready) begin
                got = rd;
                if (check_lit) check32("rd_literal", rd, lit);
            end
            @(posedge g_clk);
            #1;
        end
        valid = 1'b0;
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        repeat (n) begin
            @(posedge g_clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] got2;
        logic [31:0] orig;
        logic [31:0] r;

        cmp_on   = 1'b0;
        g_resetn = 1'b0;
        valid    = 1'b0;
        rs1      = 32'h0;
        rs2      = 32'h0;
        enc      = 1'b1;

        for (int x = 0; x < 256; x++) fwd_tab[x] = ref_sbox(x[7:0]);
        for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = x[7:0];
        check32("model_s00", {24'd0, fwd_tab[8'h00]}, 32'h63);
        check32("model_s01", {24'd0, fwd_tab[8'h01]}, 32'h7c);
        check32("model_s53", {24'd0, fwd_tab[8'h53]}, 32'hed);
        check32("model_sff", {24'd0, fwd_tab[8'hff]}, 32'h16);
        check32("model_i63", {24'd0, inv_tab[8'h63]}, 32'h00);

        repeat (3) @(posedge g_clk);
        #1;
        g_resetn = 1'b1;
        @(negedge g_clk);
        check32("reset_ready", {31'd0, ready}, 32'd0);
        check32("reset_bytes", {8'h00, rd[23:0]}, 32'h0);
        @(posedge g_clk);
        #1;
        cmp_on = 1'b1;

        // Forward and inverse literal vectors
        run_op(32'h00000100, 32'hFF530000, 1'b1, 4, 1'b1, 32'h16ED7C63, got);
        idle(2);
        run_op(32'h00007C63, 32'h16ED0000, 1'b0, 4, 1'b1, 32'hFF530100, got);

        // Back-to-back: 8 valid cycles, ready at 3 and 7
        run_op(32'h00000100, 32'hFF530000, 1'b1, 8, 1'b1, 32'h16ED7C63, got);
        idle(1);

        // Abort after 2 cycles, gap of 1, then full op
        run_op(32'h12345678, 32'h9ABCDEF0, 1'b1, 2, 1'b0, 32'h0, got);
        idle(1);
        run_op(32'h00007C63, 32'h16ED0000, 1'b0, 4, 1'b1, 32'hFF530100, got);
        idle(1);

        // Reset in cycle 2 of an op
        run_op(32'h00000100, 32'hFF530000, 1'b1, 2, 1'b0, 32'h0, got);
        valid    = 1'b1;
        g_resetn = 1'b0;
        @(negedge g_clk);
        check32("ready_in_reset", {31'd0, ready}, 32'd0);
        @(posedge g_clk);
        #1;
        g_resetn = 1'b1;
        run_op(32'h00000100, 32'hFF530000, 1'b1, 4, 1'b1, 32'h16ED7C63, got);
        idle(1);

        // Exhaustive x0 with round trip through both directions
        for (int x = 0; x < 256; x++) begin
            r    = $urandom;
            orig = {r[31:8], x[7:0]};
            run_op({16'h0, orig[15:0]}, {orig[31:16], 16'h0}, 1'b1, 4, 1'b0, 32'h0, got);
            check32("fwd_x0", {24'd0, got[7:0]}, {24'd0, fwd_tab[x]});
            run_op({$urandom_range(0, 65535), got[15:0]}, {got[31:16], 16'h0}, 1'b0, 4, 1'b0, 32'h0, got2);
            check32("round_trip", got2, orig);
            r = $urandom;
            run_op({16'h0, r[15:8], x[7:0]}, {r[31:16], 16'h0}, 1'b0, 4, 1'b0, 32'h0, got);
            check32("inv_x0", {24'd0, got[7:0]}, {24'd0, inv_tab[x]});
        end

        // Random traffic: valid gaps, occasional resets, operands held mid-op
        for (int n = 0; n < 1500; n++) begin
            if (run_len == 0) begin
                rs1 = $urandom;
                rs2 = $urandom;
                enc = 1'($urandom_range(0, 1));
            end
            valid    = ($urandom_range(0, 5) != 0);
            g_resetn = ($urandom_range(0, 60) != 0);
            @(posedge g_clk);
            #1;
        end
        g_resetn = 1'b1;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL timeout got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
